pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Produces per-latch freeze/flush and PC enable/redirect from cache hits, load-use hazards,
//  branch/jump resolution in MEM, and halt. Holds run/dwait/halt FSM and stall statistics.
//  Sits beside the datapath; its outputs drive the latches' freeze/flush inputs and the PC.
// PARAMETERS
//  DWAIT_MAX  256  cycles DWAIT may persist before dwait_err is set (sticky)
//  CNT_W      32   width of stall/flush statistic counters
// PORTS
//  CLK            in   1      clock, rising edge
//  nRST           in   1      reset, asynchronous, active-low
//  ihit           in   1      icache returned instruction this cycle
//  dhit           in   1      dcache completed MEM-stage access this cycle
//  exmem_dreq     in   1      EX/MEM holds load or store (mem_read_o | mem_write_o)
//  exmem_redirect in   1      EX/MEM holds taken branch (beq&zero | bne&!zero) or jump
//  exmem_halt     in   1      EX/MEM holds halt
//  idex_mem_read  in   1      ID/EX holds a load
//  idex_wsel      in   5      ID/EX destination register
//  ifid_rs        in   5      IF/ID source rs
//  ifid_rt        in   5      IF/ID source rt
//  pc_en          out  1      PC register may update
//  pc_redirect    out  1      PC selects EX/MEM target (branch/jump address)
//  ifid_freeze    out  1      }
//  ifid_flush     out  1      }
//  idex_freeze    out  1      } per-latch controls; flush has priority in latch
//  idex_flush     out  1      }
//  exmem_freeze   out  1      }
//  exmem_flush    out  1      }
//  memwb_freeze   out  1      }
//  memwb_flush    out  1      }
//  halted         out  1      registered; 1 from cycle after halt leaves EX/MEM until reset
//  dwait_err      out  1      registered sticky; DWAIT exceeded DWAIT_MAX
//  stall_cnt      out  CNT_W  registered; cycles with pc_en=0 in RUN/DWAIT
//  flush_cnt      out  CNT_W  registered; redirects taken
// BEHAVIOUR
//  States: RUN, DWAIT, HALT. Reset -> RUN; halted=0, dwait_err=0, counters=0, wait ctr=0.
//  Control outputs combinational from state+inputs; defaults 0, pc_en=1. Priority in RUN/DWAIT:
//   1 exmem_halt: ifid/idex/exmem_flush=1, pc_en=0; next HALT.
//   2 exmem_dreq & !dhit: pc_en=0, ifid/idex/exmem_freeze=1, memwb_flush=1; next DWAIT.
//   3 exmem_redirect: pc_en=1, pc_redirect=1, ifid/idex/exmem_flush=1; flush_cnt+1.
//   4 load-use (idex_mem_read & idex_wsel!=0 & idex_wsel in {ifid_rs,ifid_rt}):
//     pc_en=0, ifid_freeze=1, idex_flush=1.
//   5 !ihit: pc_en=0, ifid_flush=1 (bubble), later stages advance.
//   else: all advance. Rule 4 overrides 5 (IF/ID held, not flushed).
//  DWAIT: same rules; dhit -> rules 3-5 apply that cycle, next RUN. Wait ctr increments
//   per DWAIT cycle, clears on exit; reaching DWAIT_MAX sets dwait_err (FSM keeps waiting).
//  HALT: pc_en=0; ifid/idex/exmem_flush=1, memwb_flush=1 (halt drains WB on entry cycle).
//   Only nRST exits. halted=1 on the first HALT cycle.
//  Counters saturate at all-ones; stall_cnt counts rule 2/4/5 cycles and DWAIT cycles.
//  Redirect cannot coincide with rule 2 effect: a miss freezes the redirecting instr;
//   redirect fires on its dhit cycle. Async reset mid-DWAIT/HALT -> RUN same instant.
// STRUCTURE
//  cpu_types_pkg: pctrl_state_t enum {RUN,DWAIT,HALT}; latch_ctrl_t struct {freeze,flush}.
//  Sub-module hazard_detect: combinational load-use compare (idex_*, ifid_*) -> lu_stall.
//  Top: FSM reg, wait counter, stat counters, priority encoder for outputs.
// TESTING
//  ihit=1,no hazards 10 cyc -> pc_en=1, all freeze/flush 0, stall_cnt=0.
//  lw $2 in ID/EX, ifid_rs=2 -> 1 cycle pc_en=0, ifid_freeze=1, idex_flush=1; stall_cnt=1.
//  exmem_dreq=1, dhit low 3 cyc -> DWAIT, front freezes+memwb_flush 3 cyc, RUN on dhit.
//  exmem_redirect=1 & !ihit -> pc_redirect=1, three flushes, flush_cnt=1, pc_en=1.
//  DWAIT_MAX=4, dhit held 0 6 cyc -> dwait_err=1 after 4th, sticky; nRST clears to 0.
//  exmem_halt=1 -> next cycle HALT, halted=1, pc_en=0 forever; nRST mid-HALT -> RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_types_pkg : shared types for the pipeline sequencer                     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic freeze;
        logic flush;
    } latch_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// +----------------------------------------------------------------------------+
// | hazard_detect : load-use compare between ID/EX and IF/ID                    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_detect (
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_wsel_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       lu_stall_o
);

    // $zero is never a real dependency
    assign lu_stall_o = idex_mem_read_i && (idex_wsel_i != 5'd0) &&
                        ((idex_wsel_i == ifid_rs_i) || (idex_wsel_i == ifid_rt_i));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipeline_ctrl : RUN/DWAIT/HALT sequencer driving latch freeze/flush and PC  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DWAIT_MAX = 256,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit_i,
    input  logic             dhit_i,
    input  logic             exmem_dreq_i,
    input  logic             exmem_redirect_i,
    input  logic             exmem_halt_i,
    input  logic             idex_mem_read_i,
    input  logic [4:0]       idex_wsel_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    output logic             pc_en_o,
    output logic             pc_redirect_o,
    output logic             ifid_freeze_o,
    output logic             ifid_flush_o,
    output logic             idex_freeze_o,
    output logic             idex_flush_o,
    output logic             exmem_freeze_o,
    output logic             exmem_flush_o,
    output logic             memwb_freeze_o,
    output logic             memwb_flush_o,
    output logic             halted_o,
    output logic             dwait_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int                WAIT_W      = $clog2(DWAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(DWAIT_MAX - 1);

    pctrl_state_t      state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              halted_q;
    logic              dwait_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    latch_ctrl_t w_ifid, w_idex, w_exmem, w_memwb;
    logic        w_pc_en, w_pc_redirect;
    logic        w_stall, w_redir_taken;
    logic        w_lu_stall;

    hazard_detect u_hazard (
        .idex_mem_read_i (idex_mem_read_i),
        .idex_wsel_i     (idex_wsel_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .lu_stall_o      (w_lu_stall)
    );

    always_comb begin
        w_pc_en       = 1'b1;
        w_pc_redirect = 1'b0;
        w_ifid        = '0;
        w_idex        = '0;
        w_exmem       = '0;
        w_memwb       = '0;
        w_stall       = 1'b0;
        w_redir_taken = 1'b0;
        state_d       = state_q;

        if (state_q == HALT) begin
            w_pc_en       = 1'b0;
            w_ifid.flush  = 1'b1;
            w_idex.flush  = 1'b1;
            w_exmem.flush = 1'b1;
            w_memwb.flush = 1'b1;
        end else if (exmem_halt_i) begin
            w_pc_en       = 1'b0;
            w_ifid.flush  = 1'b1;
            w_idex.flush  = 1'b1;
            w_exmem.flush = 1'b1;
            state_d       = HALT;
        end else if (exmem_dreq_i && !dhit_i) begin
            // Hold the memory op in EX/MEM; WB gets a bubble meanwhile
            w_pc_en        = 1'b0;
            w_ifid.freeze  = 1'b1;
            w_idex.freeze  = 1'b1;
            w_exmem.freeze = 1'b1;
            w_memwb.flush  = 1'b1;
            w_stall        = 1'b1;
            state_d        = DWAIT;
        end else begin
            state_d = RUN;
            if (exmem_redirect_i) begin
                w_pc_redirect = 1'b1;
                w_ifid.flush  = 1'b1;
                w_idex.flush  = 1'b1;
                w_exmem.flush = 1'b1;
                w_redir_taken = 1'b1;
            end else if (w_lu_stall) begin
                // Load-use holds IF/ID even on an icache miss
                w_pc_en       = 1'b0;
                w_ifid.freeze = 1'b1;
                w_idex.flush  = 1'b1;
                w_stall       = 1'b1;
            end else if (!ihit_i) begin
                w_pc_en      = 1'b0;
                w_ifid.flush = 1'b1;
                w_stall      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            wait_q      <= '0;
            halted_q    <= 1'b0;
            dwait_err_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);

            if ((state_q == DWAIT) && (state_d == DWAIT)) begin
                if (wait_q != c_WAIT_LAST)
                    wait_q <= wait_q + WAIT_W'(1);
                if (wait_q == c_WAIT_LAST)
                    dwait_err_q <= 1'b1;
            end else begin
                wait_q <= '0;
            end

            if (w_stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (w_redir_taken && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign pc_en_o        = w_pc_en;
    assign pc_redirect_o  = w_pc_redirect;
    assign ifid_freeze_o  = w_ifid.freeze;
    assign ifid_flush_o   = w_ifid.flush;
    assign idex_freeze_o  = w_idex.freeze;
    assign idex_flush_o   = w_idex.flush;
    assign exmem_freeze_o = w_exmem.freeze;
    assign exmem_flush_o  = w_exmem.flush;
    assign memwb_freeze_o = w_memwb.freeze;
    assign memwb_flush_o  = w_memwb.flush;
    assign halted_o       = halted_q;
    assign dwait_err_o    = dwait_err_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_ctrl : directed self-checking bench for pipeline_ctrl           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // ctrl bit order: pc_en, pc_redirect, ifid fz/fl, idex fz/fl, exmem fz/fl, memwb fz/fl
    localparam logic [9:0] c_ADV   = 10'b10_00_00_00_00;
    localparam logic [9:0] c_LU    = 10'b00_10_01_00_00;
    localparam logic [9:0] c_IMISS = 10'b00_01_00_00_00;
    localparam logic [9:0] c_DMISS = 10'b00_10_10_10_01;
    localparam logic [9:0] c_REDIR = 10'b11_01_01_01_00;
    localparam logic [9:0] c_HALTI = 10'b00_01_01_01_00;
    localparam logic [9:0] c_HALTS = 10'b00_01_01_01_01;

    logic             CLK, nRST;
    logic             ihit, dhit, dreq, redir, halt, mr;
    logic [4:0]       wsel, rs, rt;
    logic             pc_en, pc_redirect;
    logic             ifid_fz, ifid_fl, idex_fz, idex_fl;
    logic             exmem_fz, exmem_fl, memwb_fz, memwb_fl;
    logic             halted, dwait_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [9:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.DWAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .ihit_i           (ihit),
        .dhit_i           (dhit),
        .exmem_dreq_i     (dreq),
        .exmem_redirect_i (redir),
        .exmem_halt_i     (halt),
        .idex_mem_read_i  (mr),
        .idex_wsel_i      (wsel),
        .ifid_rs_i        (rs),
        .ifid_rt_i        (rt),
        .pc_en_o          (pc_en),
        .pc_redirect_o    (pc_redirect),
        .ifid_freeze_o    (ifid_fz),
        .ifid_flush_o     (ifid_fl),
        .idex_freeze_o    (idex_fz),
        .idex_flush_o     (idex_fl),
        .exmem_freeze_o   (exmem_fz),
        .exmem_flush_o    (exmem_fl),
        .memwb_freeze_o   (memwb_fz),
        .memwb_flush_o    (memwb_fl),
        .halted_o         (halted),
        .dwait_err_o      (dwait_err),
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
    );

    assign ctrl = {pc_en, pc_redirect, ifid_fz, ifid_fl, idex_fz, idex_fl,
                   exmem_fz, exmem_fl, memwb_fz, memwb_fl};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check combinational controls mid-cycle, then advance one clock edge
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge CLK);
        check_eq(tag, {22'd0, ctrl}, {22'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic neutral();
        ihit = 1'b1; dhit = 1'b0; dreq = 1'b0; redir = 1'b0; halt = 1'b0;
        mr = 1'b0; wsel = 5'd0; rs = 5'd0; rt = 5'd0;
    endtask

    initial begin
        nRST = 1'b0;
        neutral();
        #1;
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_err", {31'd0, dwait_err}, 32'd0);
        check_eq("rst_stall", stall_cnt, 32'd0);
        check_eq("rst_flush", flush_cnt, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 10; i++) cyc("idle", c_ADV);
        check_eq("idle_stall", stall_cnt, 32'd0);

        // load-use hazards
        mr = 1'b1; wsel = 5'd2; rs = 5'd2; rt = 5'd7;
        cyc("lu_rs", c_LU);
        check_eq("lu_rs_stall", stall_cnt, 32'd1);
        wsel = 5'd0; rs = 5'd0; rt = 5'd0;
        cyc("lu_zero", c_ADV);
        wsel = 5'd5; rs = 5'd1; rt = 5'd5;
        cyc("lu_rt", c_LU);
        mr = 1'b0;
        cyc("lu_nomr", c_ADV);
        check_eq("lu_stall2", stall_cnt, 32'd2);
        mr = 1'b1; ihit = 1'b0;
        cyc("lu_imiss", c_LU);
        mr = 1'b0;
        cyc("imiss", c_IMISS);
        check_eq("imiss_stall", stall_cnt, 32'd4);
        neutral();

        // dcache miss for three cycles, released on dhit
        dreq = 1'b1;
        for (int i = 0; i < 3; i++) cyc("dmiss", c_DMISS);
        dhit = 1'b1;
        cyc("dhit_exit", c_ADV);
        check_eq("dmiss_stall", stall_cnt, 32'd7);
        check_eq("dmiss_err", {31'd0, dwait_err}, 32'd0);
        neutral();

        // redirect beats icache miss
        redir = 1'b1; ihit = 1'b0;
        cyc("redir", c_REDIR);
        check_eq("redir_flush", flush_cnt, 32'd1);
        check_eq("redir_stall", stall_cnt, 32'd7);
        neutral();

        // redirect fires on the dhit cycle of a waiting access
        dreq = 1'b1;
        cyc("dmiss_r", c_DMISS);
        dhit = 1'b1; redir = 1'b1;
        cyc("dhit_redir", c_REDIR);
        check_eq("dhit_redir_flush", flush_cnt, 32'd2);
        check_eq("dhit_redir_stall", stall_cnt, 32'd8);
        neutral();

        // DWAIT timeout: error after the 4th DWAIT cycle, sticky
        dreq = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc("dw_ctrl", c_DMISS);
            check_eq("dw_err", {31'd0, dwait_err}, (k >= 5) ? 32'd1 : 32'd0);
        end
        dhit = 1'b1;
        cyc("dw_exit", c_ADV);
        check_eq("dw_sticky", {31'd0, dwait_err}, 32'd1);
        check_eq("dw_stall", stall_cnt, 32'd14);
        neutral();
        nRST = 1'b0;
        #1;
        check_eq("dw_rst_err", {31'd0, dwait_err}, 32'd0);
        check_eq("dw_rst_stall", stall_cnt, 32'd0);
        check_eq("dw_rst_flush", flush_cnt, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // halt
        halt = 1'b1;
        cyc("halt_in", c_HALTI);
        check_eq("halted1", {31'd0, halted}, 32'd1);
        neutral();
        ihit = 1'b0; dreq = 1'b1; redir = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt_st", c_HALTS);
        check_eq("halt_hold", {31'd0, halted}, 32'd1);
        check_eq("halt_stall", stall_cnt, 32'd0);
        check_eq("halt_flush", flush_cnt, 32'd0);
        neutral();
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_eq("halt_rst", {31'd0, halted}, 32'd0);
        check_eq("halt_rst_ctrl", {22'd0, ctrl}, {22'd0, c_ADV});
        @(posedge CLK);
        #1 nRST = 1'b1;
        cyc("post_halt", c_ADV);
        check_eq("post_halted", {31'd0, halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
